// File: rtl/cpu_pc.sv
// rtl/cpu_pc.sv - program counter with return-address stack for call/return sequencing
//
// Ports:
//   CLK          system clock, all state changes on the rising edge
//   RST_N        asynchronous active-low reset
//   EN           advance enable; when low every piece of state holds
//   JMP          load PC from JMP_ADDR
//   CALL         push PC+1 then load PC from JMP_ADDR
//   RET          pop the most recent return address into PC
//   JMP_ADDR     target address for JMP and CALL
//   PC_OUT       current program address (registered)
//   STACK_LEVEL  number of valid return-address entries
//   STACK_EMPTY  STACK_LEVEL == 0
//   STACK_FULL   STACK_LEVEL == DEPTH
//   STACK_ERR    sticky overflow/underflow flag, cleared only by reset

module cpu_pc #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic                       JMP,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [WIDTH-1:0]           JMP_ADDR,
  output logic [WIDTH-1:0]           PC_OUT,
  output logic [$clog2(DEPTH):0]     STACK_LEVEL,
  output logic                       STACK_EMPTY,
  output logic                       STACK_FULL,
  output logic                       STACK_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [LW-1:0]    level_dec;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic             do_push;

  assign pc_inc      = PC_OUT + 1'b1;
  assign level_dec   = STACK_LEVEL - 1'b1;

  // The stack is a plain array addressed by the level counter: the next free
  // slot is STACK_LEVEL, the top of stack is STACK_LEVEL-1. Both indices fit
  // in AW bits whenever they are actually used (not full / not empty).
  assign push_idx    = STACK_LEVEL[AW-1:0];
  assign pop_idx     = level_dec[AW-1:0];

  assign STACK_EMPTY = (STACK_LEVEL == '0);
  assign STACK_FULL  = (STACK_LEVEL == LW'(DEPTH));

  // A push only happens when CALL wins priority (no RET) and there is room.
  assign do_push     = EN && !RET && CALL && !STACK_FULL;

  // Entry contents are not reset; only the level is, which discards them.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC_OUT      <= '0;
      STACK_LEVEL <= '0;
      STACK_ERR   <= 1'b0;
    end else if (EN) begin
      if (RET) begin
        if (!STACK_EMPTY) begin
          PC_OUT      <= stack_mem[pop_idx];
          STACK_LEVEL <= level_dec;
        end else begin
          // Underflow: behave as a plain increment and flag it.
          PC_OUT    <= pc_inc;
          STACK_ERR <= 1'b1;
        end
      end else if (CALL) begin
        if (!STACK_FULL) begin
          PC_OUT      <= JMP_ADDR;
          STACK_LEVEL <= STACK_LEVEL + 1'b1;
        end else begin
          // Overflow: drop the call, fall through to the next instruction.
          PC_OUT    <= pc_inc;
          STACK_ERR <= 1'b1;
        end
      end else if (JMP) begin
        PC_OUT <= JMP_ADDR;
      end else begin
        PC_OUT <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_cpu_pc.sv
// tb/tb_cpu_pc.sv - self-checking bench for cpu_pc with directed and random stimulus

module tb_cpu_pc;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       JMP;
  logic       CALL;
  logic       RET;
  logic [7:0] JMP_ADDR;
  logic [7:0] PC_OUT;
  logic [2:0] STACK_LEVEL;
  logic       STACK_EMPTY;
  logic       STACK_FULL;
  logic       STACK_ERR;

  int checks   = 0;
  int failures = 0;

  // Reference model: PC as an integer, the return stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_err;

  cpu_pc #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .JMP         (JMP),
    .CALL        (CALL),
    .RET         (RET),
    .JMP_ADDR    (JMP_ADDR),
    .PC_OUT      (PC_OUT),
    .STACK_LEVEL (STACK_LEVEL),
    .STACK_EMPTY (STACK_EMPTY),
    .STACK_FULL  (STACK_FULL),
    .STACK_ERR   (STACK_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_stk.delete();
    m_err = 0;
  endtask

  task automatic model_step(input bit en, input bit ret, input bit call,
                            input bit jmp, input int addr);
    if (!en) return;
    if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = (m_pc + 1) % 256; m_err = 1; end
    end else if (call) begin
      if (m_stk.size() < 4) begin
        m_stk.push_back((m_pc + 1) % 256);
        m_pc = addr;
      end else begin
        m_pc = (m_pc + 1) % 256;
        m_err = 1;
      end
    end else if (jmp) begin
      m_pc = addr;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    int'(PC_OUT),      m_pc);
    chk({tag, ".level"}, int'(STACK_LEVEL), m_stk.size());
    chk({tag, ".empty"}, int'(STACK_EMPTY), int'(m_stk.size() == 0));
    chk({tag, ".full"},  int'(STACK_FULL),  int'(m_stk.size() == 4));
    chk({tag, ".err"},   int'(STACK_ERR),   int'(m_err));
  endtask

  // Apply one cycle of inputs, clock it, and compare against the model.
  task automatic step(input string tag, input bit en, input bit ret,
                      input bit call, input bit jmp, input int addr);
    EN = en; RET = ret; CALL = call; JMP = jmp; JMP_ADDR = 8'(addr);
    @(posedge CLK);
    #1;
    model_step(en, ret, call, jmp, addr);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; JMP = 1'b0; CALL = 1'b0; RET = 1'b0; JMP_ADDR = 8'h00;
    model_reset();
    #12;
    chk("rst.pc",    int'(PC_OUT),      0);
    chk("rst.level", int'(STACK_LEVEL), 0);
    chk("rst.empty", int'(STACK_EMPTY), 1);
    chk("rst.full",  int'(STACK_FULL),  0);
    chk("rst.err",   int'(STACK_ERR),   0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Sequencing and hold
    step("seq1", 1, 0, 0, 0, 0); chk("seq1.const", int'(PC_OUT), 'h01);
    step("seq2", 1, 0, 0, 0, 0); chk("seq2.const", int'(PC_OUT), 'h02);
    step("seq3", 1, 0, 0, 0, 0); chk("seq3.const", int'(PC_OUT), 'h03);
    step("hold1", 0, 0, 1, 1, 'h77); chk("hold1.const", int'(PC_OUT), 'h03);
    step("hold2", 0, 1, 0, 0, 0);    chk("hold2.const", int'(PC_OUT), 'h03);

    // Jump and wrap
    step("jmp", 1, 0, 0, 1, 'hFE); chk("jmp.const", int'(PC_OUT), 'hFE);
    step("wrap1", 1, 0, 0, 0, 0);  chk("wrap1.const", int'(PC_OUT), 'hFF);
    step("wrap2", 1, 0, 0, 0, 0);  chk("wrap2.const", int'(PC_OUT), 'h00);
    chk("wrap2.err", int'(STACK_ERR), 0);

    // Call / return
    step("to10", 1, 0, 0, 1, 'h10);
    step("call1", 1, 0, 1, 0, 'hA7); chk("call1.const", int'(PC_OUT), 'hA7);
    chk("call1.lvl", int'(STACK_LEVEL), 1);
    step("call2", 1, 0, 1, 0, 'h12); chk("call2.const", int'(PC_OUT), 'h12);
    chk("call2.lvl", int'(STACK_LEVEL), 2);
    step("ret1", 1, 1, 0, 0, 0); chk("ret1.const", int'(PC_OUT), 'hA8);
    step("ret2", 1, 1, 0, 0, 0); chk("ret2.const", int'(PC_OUT), 'h11);
    chk("ret2.empty", int'(STACK_EMPTY), 1);

    // Overflow: fourth call lands on 0x30, fifth call overflows
    step("f1", 1, 0, 1, 0, 'h20);
    step("f2", 1, 0, 1, 0, 'h24);
    step("f3", 1, 0, 1, 0, 'h28);
    step("f4", 1, 0, 1, 0, 'h30); chk("f4.full", int'(STACK_FULL), 1);
    step("ovf", 1, 0, 1, 0, 'h99); chk("ovf.const", int'(PC_OUT), 'h31);
    chk("ovf.lvl", int'(STACK_LEVEL), 4);
    chk("ovf.err", int'(STACK_ERR), 1);
    step("ovf.inc", 1, 0, 0, 0, 0);
    step("ovf.ret", 1, 1, 0, 0, 0); chk("ovf.sticky", int'(STACK_ERR), 1);

    // Underflow and priority
    do_reset();
    step("to05", 1, 0, 0, 1, 'h05);
    step("unf", 1, 1, 1, 1, 'h80); chk("unf.const", int'(PC_OUT), 'h06);
    chk("unf.err", int'(STACK_ERR), 1);
    chk("unf.lvl", int'(STACK_LEVEL), 0);
    step("pc1", 1, 0, 1, 0, 'h50);
    step("pcj", 1, 0, 1, 1, 'h60); chk("pcj.const", int'(PC_OUT), 'h60);
    chk("pcj.lvl", int'(STACK_LEVEL), 2);
    step("prc", 1, 1, 1, 1, 'h90); chk("prc.const", int'(PC_OUT), 'h51);
    step("callafterret", 1, 0, 1, 0, 'h70);
    step("retaftercall", 1, 1, 0, 0, 0);

    // Async reset mid-cycle with level 2 and PC 0x40, error flag set
    do_reset();
    step("a.unf", 1, 1, 0, 0, 0);
    step("a.c1", 1, 0, 1, 0, 'h20);
    step("a.c2", 1, 0, 1, 0, 'h3F);
    step("a.inc", 1, 0, 0, 0, 0);
    chk("a.pre.pc",  int'(PC_OUT), 'h40);
    chk("a.pre.lvl", int'(STACK_LEVEL), 2);
    EN = 1'b1; RET = 1'b0; CALL = 1'b0; JMP = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("arst.pc",    int'(PC_OUT),      0);
    chk("arst.level", int'(STACK_LEVEL), 0);
    chk("arst.empty", int'(STACK_EMPTY), 1);
    chk("arst.full",  int'(STACK_FULL),  0);
    chk("arst.err",   int'(STACK_ERR),   0);
    @(posedge CLK);
    #1;
    chk("arst.hold", int'(PC_OUT), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step("resume", 1, 0, 0, 0, 0); chk("resume.const", int'(PC_OUT), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit en, ret, call, jmp;
      en   = ($urandom_range(0, 9) != 0);
      ret  = ($urandom_range(0, 3) == 0);
      call = ($urandom_range(0, 2) == 0);
      jmp  = ($urandom_range(0, 3) == 0);
      step("rand", en, ret, call, jmp, int'($urandom_range(0, 255)));
      if (i == 200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_pc.md
CPU_PC -- requirements
Module: cpu_pc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning program address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of return-address stack entries (power of two, >= 2).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port EN  input  1  advance enable; when 0 all state holds.
REQ-006 SHALL have port JMP  input  1  load PC from JMP_ADDR (jump-address generator output).
REQ-007 SHALL have port CALL  input  1  push return address, then load PC from JMP_ADDR.
REQ-008 SHALL have port RET  input  1  pop return address into PC.
REQ-009 SHALL have port JMP_ADDR  input  WIDTH  target address for JMP/CALL.
REQ-010 SHALL have port PC_OUT  output  WIDTH  current program address, registered.
REQ-011 SHALL have port STACK_LEVEL  output  $clog2(DEPTH)+1  number of valid stack entries.
REQ-012 SHALL have port STACK_EMPTY  output  1  high when STACK_LEVEL == 0.
REQ-013 SHALL have port STACK_FULL  output  1  high when STACK_LEVEL == DEPTH.
REQ-014 SHALL have port STACK_ERR  output  1  sticky overflow/underflow flag.

Function
REQ-015 SHALL, on a rising CLK edge with EN=1, select the next PC by fixed priority RET > CALL > JMP > increment; lower-priority requests in the same cycle are ignored.
REQ-016 SHALL, on increment, set PC_OUT <= PC_OUT + 1 modulo 2^WIDTH (all-ones wraps to 0, no flag).
REQ-017 SHALL, on JMP (highest active), set PC_OUT <= JMP_ADDR with no stack change.
REQ-018 SHALL, on CALL with STACK_FULL=0, write (PC_OUT + 1) mod 2^WIDTH to the stack top, increment STACK_LEVEL, and set PC_OUT <= JMP_ADDR, all in the same edge.
REQ-019 SHALL, on CALL with STACK_FULL=1, leave stack unchanged, increment PC_OUT, and set STACK_ERR.
REQ-020 SHALL, on RET with STACK_EMPTY=0, set PC_OUT <= most recently pushed entry and decrement STACK_LEVEL (LIFO).
REQ-021 SHALL, on RET with STACK_EMPTY=1, leave stack unchanged, increment PC_OUT, and set STACK_ERR.
REQ-022 SHALL keep STACK_ERR high once set until reset; it SHALL not affect subsequent normal operation.
REQ-023 SHALL, with EN=0, hold PC_OUT, stack contents, STACK_LEVEL and STACK_ERR regardless of JMP/CALL/RET.
REQ-024 SHALL have one-cycle latency: the effect of a request sampled at edge N is visible on PC_OUT and flags immediately after edge N.
REQ-025 SHALL derive STACK_EMPTY and STACK_FULL combinationally from the registered STACK_LEVEL only.
REQ-026 SHALL support CALL on the cycle directly following RET and vice versa with no bubble.

Reset
REQ-027 SHALL, while RST_N=0, force PC_OUT=0, STACK_LEVEL=0, STACK_EMPTY=1, STACK_FULL=0, STACK_ERR=0, asynchronously, independent of CLK.
REQ-028 SHALL, on reset asserted mid-operation, discard all stack contents; stack entry contents need not be cleared, only STACK_LEVEL.
REQ-029 SHALL resume normal operation on the first rising CLK edge after RST_N deasserts.

Verification
REQ-030 SHALL verify sequencing: reset, EN=1 for 3 cycles -> PC_OUT 0x01, 0x02, 0x03; EN=0 for 2 cycles -> PC_OUT stays 0x03.
REQ-031 SHALL verify jump and wrap: JMP=1, JMP_ADDR=0xFE -> PC_OUT 0xFE; then two increments -> 0xFF, 0x00, STACK_ERR=0.
REQ-032 SHALL verify call/return: PC_OUT=0x10, CALL with JMP_ADDR=0xA7 -> PC_OUT 0xA7, STACK_LEVEL 1; CALL with 0x12 -> 0x12, level 2; RET -> 0xA8; RET -> 0x11, STACK_EMPTY=1.
REQ-033 SHALL verify overflow: 4 CALLs fill stack (STACK_FULL=1); 5th CALL from PC 0x30 -> PC_OUT 0x31, level stays 4, STACK_ERR=1 and stays 1.
REQ-034 SHALL verify underflow and priority: empty stack, RET+CALL+JMP together from PC 0x05 -> PC_OUT 0x06, STACK_ERR=1; nonempty stack, CALL+JMP together -> CALL taken.
REQ-035 SHALL verify async reset: RST_N pulled low between clock edges with STACK_LEVEL=2, PC_OUT=0x40 -> PC_OUT=0x00, STACK_LEVEL=0, STACK_ERR=0 before the next CLK edge.
